// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: LSB has fixed priority over instruction fetch.
// Define MEM_ARB_IO_STALL_EN to stall IO-space byte writes while io_buffer_full is high.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic [31:0] if_data_out,
    output logic        if_done_out,
    input  logic        lsb_req_in,
    input  logic        lsb_we_in,
    input  logic [1:0]  lsb_size_in,
    input  logic [31:0] lsb_addr_in,
    input  logic [31:0] lsb_wdata_in,
    output logic [31:0] lsb_rdata_out,
    output logic        lsb_done_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

`ifdef MEM_ARB_IO_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [2:0]  k;
    logic [2:0]  n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic        we;
    logic        sel_lsb;
    logic        fresh;
    logic        wr_q;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic blocked(input logic [31:0] a, input logic full);
        return STALL_EN && (a >= IO_BASE) && full;
    endfunction

    logic [31:0] cur_a;
    logic [31:0] next_a;
    logic [2:0]  k_next;
    logic [1:0]  cap_idx;
    logic [31:0] cap_data;
    logic [31:0] grant_addr;
    logic        grant_we;

    assign cur_a      = addr + {29'b0, k};
    assign next_a     = cur_a + 32'd1;
    assign k_next     = k + 3'd1;
    assign cap_idx    = k[1:0] - 2'd1;
    assign grant_addr = lsb_req_in ? lsb_addr_in : if_addr_in;
    assign grant_we   = lsb_req_in & lsb_we_in;

    // A read byte arrives the cycle after its address; it is taken on the
    // first cycle of each step, so a frozen step cannot overwrite it.
    always_comb begin
        // NOTE: default first so every path assigns cap_data and no latch is inferred.
        cap_data = rbuf;
        if (fresh && k != 3'd0)
            cap_data[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    // Writes are suppressed while the core is stalled; everything else holds.
    assign mem_wr = wr_q & rdy_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= 3'd0;
            n             <= 3'd0;
            addr          <= 32'd0;
            wdata         <= 32'd0;
            rbuf          <= 32'd0;
            we            <= 1'b0;
            sel_lsb       <= 1'b0;
            fresh         <= 1'b0;
            wr_q          <= 1'b0;
            mem_a         <= 32'd0;
            mem_dout      <= 8'd0;
            if_done_out   <= 1'b0;
            lsb_done_out  <= 1'b0;
            if_data_out   <= 32'd0;
            lsb_rdata_out <= 32'd0;
        end else begin
            // NOTE: non-blocking everywhere here; later assignments in this block win.
            fresh <= 1'b0;
            if (state == RUN && !we)
                rbuf <= cap_data;
            if (rdy_in) begin
                case (state)
                    IDLE: begin
                        if (lsb_req_in || if_req_in) begin
                            state    <= RUN;
                            sel_lsb  <= lsb_req_in;
                            we       <= grant_we;
                            addr     <= grant_addr;
                            n        <= lsb_req_in ? size_bytes(lsb_size_in) : 3'd4;
                            wdata    <= lsb_wdata_in;
                            k        <= 3'd0;
                            fresh    <= 1'b1;
                            rbuf     <= 32'd0;
                            mem_a    <= grant_addr;
                            mem_dout <= grant_we ? lsb_wdata_in[7:0] : 8'd0;
                            wr_q     <= grant_we && !blocked(grant_addr, io_buffer_full);
                        end
                    end
                    RUN: begin
                        if (we) begin
                            if (wr_q) begin
                                if (k == n - 3'd1) begin
                                    state    <= DONE;
                                    wr_q     <= 1'b0;
                                    mem_a    <= 32'd0;
                                    mem_dout <= 8'd0;
                                    if (sel_lsb) lsb_done_out <= 1'b1;
                                    else         if_done_out  <= 1'b1;
                                end else begin
                                    k        <= k_next;
                                    mem_a    <= next_a;
                                    mem_dout <= wdata[{k_next[1:0], 3'b000} +: 8];
                                    // An IO byte write is followed by one idle cycle.
                                    if (STALL_EN && cur_a >= IO_BASE)
                                        wr_q <= 1'b0;
                                    else
                                        wr_q <= !blocked(next_a, io_buffer_full);
                                end
                            end else begin
                                wr_q <= !blocked(mem_a, io_buffer_full);
                            end
                        end else if (clear_in) begin
                            state <= IDLE;
                            mem_a <= 32'd0;
                        end else if (k == n) begin
                            state <= DONE;
                            mem_a <= 32'd0;
                            if (sel_lsb) begin
                                lsb_done_out  <= 1'b1;
                                lsb_rdata_out <= cap_data;
                            end else begin
                                if_done_out <= 1'b1;
                                if_data_out <= cap_data;
                            end
                        end else begin
                            k     <= k_next;
                            fresh <= 1'b1;
                            mem_a <= (k_next == n) ? 32'd0 : next_a;
                        end
                    end
                    DONE: begin
                        state        <= IDLE;
                        if_done_out  <= 1'b0;
                        lsb_done_out <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-RAM environment, a per-cycle schedule model
// of the memory bus and done/data outputs, and directed scenarios.
module tb_mem_arbiter;
    localparam logic [31:0] IO_BASE = 32'h30000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = 32'd0;
    logic [31:0] if_data_out;
    logic        if_done_out;
    logic        lsb_req_in = 1'b0;
    logic        lsb_we_in = 1'b0;
    logic [1:0]  lsb_size_in = 2'b00;
    logic [31:0] lsb_addr_in = 32'd0;
    logic [31:0] lsb_wdata_in = 32'd0;
    logic [31:0] lsb_rdata_out;
    logic        lsb_done_out;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_arbiter #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_data_out(if_data_out), .if_done_out(if_done_out),
        .lsb_req_in(lsb_req_in), .lsb_we_in(lsb_we_in), .lsb_size_in(lsb_size_in),
        .lsb_addr_in(lsb_addr_in), .lsb_wdata_in(lsb_wdata_in),
        .lsb_rdata_out(lsb_rdata_out), .lsb_done_out(lsb_done_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int io_writes = 0;

    bit [7:0] ram [logic [31:0]];

    // Expected bus activity per cycle; cycles absent from the maps are idle.
    logic [31:0] exp_a [int];
    bit          exp_w [int];
    logic [7:0]  exp_d [int];
    int          if_done_at = -1;
    int          lsb_done_at = -1;
    int          if_upd_at = -1;
    int          lsb_upd_at = -1;
    logic [31:0] if_upd = 32'd0;
    logic [31:0] lsb_upd = 32'd0;
    logic [31:0] exp_if_data = 32'd0;
    logic [31:0] exp_lsb_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rd_ram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Lay out one transfer: reads take n+1 bus steps, writes n; step i shows
    // addr+i (0 on the extra read step). hold_len stalled cycles precede step
    // hold_step; abort_steps >= 0 stops after that many steps with no done.
    task automatic plan(input bit is_lsb, input bit we, input logic [31:0] addr,
                        input int n, input logic [31:0] wdata, input int s,
                        input int hold_step, input int hold_len, input int abort_steps);
        int c;
        int steps;
        logic [31:0] a;
        logic [31:0] val;
        c = s + 1;
        steps = we ? n : n + 1;
        val = 32'd0;
        for (int i = 0; i < steps; i++) begin
            if (abort_steps >= 0 && i >= abort_steps) return;
            a = (i < n) ? addr + i : 32'd0;
            if (i == hold_step)
                for (int h = 0; h < hold_len; h++) begin
                    exp_a[c] = a; exp_w[c] = 1'b0; c++;
                end
            exp_a[c] = a; exp_w[c] = we; exp_d[c] = wdata[8*(i%4) +: 8]; c++;
        end
        for (int i = 0; i < n; i++) val |= 32'(rd_ram(addr + i)) << (8 * i);
        if (is_lsb) begin
            lsb_done_at = c;
            if (!we) begin lsb_upd_at = c; lsb_upd = val; end
        end else begin
            if_done_at = c; if_upd_at = c; if_upd = val;
        end
    endtask

    task automatic wait_done(input bit is_lsb, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (is_lsb ? lsb_done_out : if_done_out) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: no done on port lsb=%0d", is_lsb);
        end
    endtask

    initial forever @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: read data registered one cycle after the address.
    initial forever @(posedge clk) begin
        mem_din <= rd_ram(mem_a);
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            if (mem_a >= IO_BASE) io_writes++;
        end
    end

    initial forever @(negedge clk) begin
        if (cyc == if_upd_at) exp_if_data = if_upd;
        if (cyc == lsb_upd_at) exp_lsb_data = lsb_upd;
        check("mem_a", mem_a, exp_a.exists(cyc) ? exp_a[cyc] : 32'd0);
        check("mem_wr", 32'(mem_wr), exp_w.exists(cyc) ? 32'(exp_w[cyc]) : 32'd0);
        if (exp_w.exists(cyc) && exp_w[cyc]) check("mem_dout", 32'(mem_dout), 32'(exp_d[cyc]));
        check("if_done", 32'(if_done_out), 32'(cyc == if_done_at));
        check("lsb_done", 32'(lsb_done_out), 32'(cyc == lsb_done_at));
        check("if_data", if_data_out, exp_if_data);
        check("lsb_rdata", lsb_rdata_out, exp_lsb_data);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t;
        int d;
        int d2;
        int w0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h10]  = 8'h34; ram[32'h11]  = 8'h12;

        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_a", mem_a, 32'd0);
        check("reset_if_data", if_data_out, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // IF read of 0x100
        if_addr_in = 32'h100; if_req_in = 1'b1; t = cyc;
        plan(1'b0, 1'b0, 32'h100, 4, 32'd0, t, -1, 0, -1);
        wait_done(1'b0, d);
        check("if_read_latency", 32'(d - t), 32'd6);
        check("if_read_data", if_data_out, 32'h00000513);
        @(posedge clk); #1 if_req_in = 1'b0;
        repeat (2) @(posedge clk); #1;

        // 1-byte RAM write
        lsb_addr_in = 32'h20; lsb_we_in = 1'b1; lsb_size_in = 2'b00; lsb_wdata_in = 32'h5A;
        lsb_req_in = 1'b1; t = cyc;
        plan(1'b1, 1'b1, 32'h20, 1, 32'h5A, t, -1, 0, -1);
        wait_done(1'b1, d);
        check("wr1_latency", 32'(d - t), 32'd2);
        @(posedge clk); #1 lsb_req_in = 1'b0;
        check("wr1_ram", 32'(rd_ram(32'h20)), 32'h5A);
        repeat (2) @(posedge clk); #1;

        // Simultaneous requests: LSB 4B write first, IF follows without reassertion
        lsb_addr_in = 32'h200; lsb_we_in = 1'b1; lsb_size_in = 2'b10; lsb_wdata_in = 32'hDEADBEEF;
        if_addr_in = 32'h100;
        lsb_req_in = 1'b1; if_req_in = 1'b1; t = cyc;
        plan(1'b1, 1'b1, 32'h200, 4, 32'hDEADBEEF, t, -1, 0, -1);
        plan(1'b0, 1'b0, 32'h100, 4, 32'd0, t + 6, -1, 0, -1);
        wait_done(1'b1, d);
        check("prio_lsb_done_cycle", 32'(d - t), 32'd5);
        @(posedge clk); #1 lsb_req_in = 1'b0;
        wait_done(1'b0, d2);
        check("prio_if_done_cycle", 32'(d2 - t), 32'd12);
        check("prio_ram_bytes", {rd_ram(32'h203), rd_ram(32'h202), rd_ram(32'h201), rd_ram(32'h200)},
              32'hDEADBEEF);
        @(posedge clk); #1 if_req_in = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Flush in RUN cycle 2 of an IF read: three bus steps, then idle, no done
        if_addr_in = 32'h100; if_req_in = 1'b1; t = cyc;
        plan(1'b0, 1'b0, 32'h100, 4, 32'd0, t, -1, 0, 3);
        repeat (3) @(posedge clk);
        #1 clear_in = 1'b1;
        @(posedge clk); #1 clear_in = 1'b0; if_req_in = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("clear_if_data_held", if_data_out, 32'h00000513);

        // 1B write to IO space with the UART buffer full for 5 cycles
        w0 = io_writes;
        lsb_addr_in = IO_BASE; lsb_we_in = 1'b1; lsb_size_in = 2'b00; lsb_wdata_in = 32'h41;
        lsb_req_in = 1'b1; io_buffer_full = 1'b1; t = cyc;
`ifdef MEM_ARB_IO_STALL_EN
        plan(1'b1, 1'b1, IO_BASE, 1, 32'h41, t, 0, 5, -1);
`else
        plan(1'b1, 1'b1, IO_BASE, 1, 32'h41, t, -1, 0, -1);
`endif
        fork
            begin
                repeat (5) @(posedge clk);
                #1 io_buffer_full = 1'b0;
            end
            begin
                wait_done(1'b1, d);
                @(posedge clk); #1 lsb_req_in = 1'b0;
            end
        join
`ifdef MEM_ARB_IO_STALL_EN
        check("io_wr_latency", 32'(d - t), 32'd7);
`else
        check("io_wr_latency", 32'(d - t), 32'd2);
`endif
        repeat (2) @(posedge clk); #1;
        check("io_write_count", 32'(io_writes - w0), 32'd1);
        check("io_write_byte", 32'(rd_ram(IO_BASE)), 32'h41);

        // 2B read at 0x10 with rdy_in low for 3 cycles during RUN step 1
        lsb_addr_in = 32'h10; lsb_we_in = 1'b0; lsb_size_in = 2'b01;
        lsb_req_in = 1'b1; t = cyc;
        plan(1'b1, 1'b0, 32'h10, 2, 32'd0, t, 1, 3, -1);
        repeat (2) @(posedge clk);
        #1 rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_in = 1'b1;
        wait_done(1'b1, d);
        check("rdy_read_latency", 32'(d - t), 32'd7);
        check("rdy_read_data", lsb_rdata_out, 32'h00001234);
        @(posedge clk); #1 lsb_req_in = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset in the middle of a 4B write
        lsb_addr_in = 32'h300; lsb_we_in = 1'b1; lsb_size_in = 2'b10; lsb_wdata_in = 32'h11223344;
        lsb_req_in = 1'b1; t = cyc;
        plan(1'b1, 1'b1, 32'h300, 4, 32'h11223344, t, -1, 0, -1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        exp_a.delete(); exp_w.delete(); exp_d.delete();
        if_done_at = -1; lsb_done_at = -1; if_upd_at = -1; lsb_upd_at = -1;
        exp_if_data = 32'd0; exp_lsb_data = 32'd0;
        rst_n = 1'b0; lsb_req_in = 1'b0;
        #1;
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_lsb_done", 32'(lsb_done_out), 32'd0);
        check("rst_if_data", if_data_out, 32'd0);
        check("rst_lsb_rdata", lsb_rdata_out, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Recovery: IF read after reset
        if_addr_in = 32'h100; if_req_in = 1'b1; t = cyc;
        plan(1'b0, 1'b0, 32'h100, 4, 32'd0, t, -1, 0, -1);
        wait_done(1'b0, d);
        check("post_rst_latency", 32'(d - t), 32'd6);
        check("post_rst_data", if_data_out, 32'h00000513);
        @(posedge clk); #1 if_req_in = 1'b0;
        repeat (3) @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h30000, lowest address decoded as memory-mapped IO.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy_in  in  1  global enable; low freezes all state.
REQ-005 SHALL have port clear_in  in  1  pipeline flush (branch mispredict).
REQ-006 SHALL have ports if_req_in in 1, if_addr_in in 32, if_data_out out 32, if_done_out out 1  for instruction fetch (always 4-byte read).
REQ-007 SHALL have ports lsb_req_in in 1, lsb_we_in in 1, lsb_size_in in 2 (00=1B, 01=2B, 10=4B), lsb_addr_in in 32, lsb_wdata_in in 32, lsb_rdata_out out 32, lsb_done_out out 1  for load/store buffer.
REQ-008 SHALL have ports mem_din in 8, mem_dout out 8, mem_a out 32, mem_wr out 1  for byte-wide RAM; read data valid one cycle after address.
REQ-009 SHALL have port io_buffer_full  in  1  UART transmit buffer full.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE.
REQ-011 SHALL, in IDLE, grant LSB over IF when both request (fixed priority), latching requester, address, byte count N and write data, then enter RUN.
REQ-012 SHALL, in RUN cycle k (k=0..N-1), drive mem_a=addr+k; for writes, mem_wr=1 and mem_dout=wdata[8k+7:8k].
REQ-013 SHALL, for reads, capture mem_din into result bits [8(k-1)+7:8(k-1)] in RUN cycle k, and the last byte in the cycle after cycle N-1; reads SHALL use N+1 RUN cycles, writes N.
REQ-014 SHALL assert the granted done output for exactly one cycle in DONE, with if_data_out/lsb_rdata_out valid in that cycle (zero-extended, little-endian), then return to IDLE.
REQ-015 SHALL ignore all requests in the DONE cycle; requesters hold req and operands stable until done and drop req in the cycle after done.
REQ-016 SHALL drive mem_a=0, mem_wr=0 in IDLE and DONE, and never issue an address beyond addr+N-1, so an IO read has no side effect repeated.
REQ-017 SHALL give a 4-byte read latency of 6 cycles from req sampled to done high, a 1-byte write latency of 2.
REQ-018 SHALL, on clear_in high, abort any in-progress read (no done pulse) and return to IDLE next cycle; in-progress writes SHALL complete.
REQ-019 SHALL, while rdy_in low, hold state, counters and outputs, except mem_wr forced 0.
REQ-020 SHALL hold if_data_out/lsb_rdata_out stable until the next done of that port.

Reset
REQ-021 SHALL, on rst_n low, immediately enter IDLE and clear mem_a, mem_dout, mem_wr, if_done_out, lsb_done_out, if_data_out, lsb_rdata_out to 0.
REQ-022 SHALL, on reset mid-transfer, abandon the transfer with no done pulse; first grant possible in the first edge after rst_n rises.

Configuration
REQ-023 SHALL honour macro MEM_ARB_IO_STALL_EN: defined -> a write byte with address >= IO_BASE is not issued (mem_wr=0, k not advanced) while io_buffer_full is high, and one idle cycle follows each IO byte write; undefined -> io_buffer_full ignored, IO writes take the same cycles as RAM writes.

Verification
REQ-024 SHALL pass: IF read addr 0x100, RAM bytes 13,05,00,00 -> if_data_out=32'h00000513, if_done_out high 6 cycles after req sampled, single pulse.
REQ-025 SHALL pass: IF and LSB (4B write 0x200, data 32'hDEADBEEF) request same cycle -> LSB served first, bytes EF,BE,AD,DE at 0x200..0x203, then IF served without reassertion.
REQ-026 SHALL pass: IF read in RUN cycle 2, clear_in pulse -> no if_done_out, IDLE next cycle, mem_wr stays 0.
REQ-027 SHALL pass: 1B write 0x41 to 0x30000 with io_buffer_full high 5 cycles -> with MEM_ARB_IO_STALL_EN mem_wr asserted only after full drops, single write; without, written in first RUN cycle.
REQ-028 SHALL pass: rdy_in low 3 cycles during 2B read at 0x10 -> done delayed by 3 cycles, data unchanged, no extra mem_wr.
REQ-029 SHALL pass: rst_n low mid 4B write -> all outputs 0 immediately, no lsb_done_out.
